// File: rtl/cpu_pkg.sv
// Shared CPU constants: NOP encoding, instruction field positions and IF stage state encoding.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    typedef logic [1:0] if_state_t;

    localparam if_state_t FETCH = 2'd0;
    localparam if_state_t HOLD  = 2'd1;
    localparam if_state_t DROP  = 2'd2;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction memory fetch bus: request/address out, ready/data back.
interface if_id_stage_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [PC_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched word and its pc+4 while decode is stalled.
// Latency: load/unload take effect on the next edge; clear wins over load, load over unload.
// Backpressure: none of its own; the owner decides when to load and unload.
module if_skid_buf
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [PC_W-1:0] load_dat,
    input  logic [PC_W-1:0] load_pc4,
    output logic            valid,
    output logic [PC_W-1:0] data,
    output logic [PC_W-1:0] pc4
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            data  <= PC_W'(NOP_INSTR);
            pc4   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_dat;
            pc4   <= load_pc4;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/if_id_stage.sv
// IF/ID stage: fetch FSM (FETCH/HOLD/DROP), IF/ID register and skid buffer; optional IF_PERF_CNT_EN counters.
// Latency: one instruction per cycle with imem_ready held high; IF/ID loads on the accepting edge.
// Backpressure: stall parks a returned word in the skid buffer and drops imem_req until released.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    if_id_stage_if.master   imem,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            if_id_valid,
    output logic [PC_W-1:0] if_id_instr,
    output logic [PC_W-1:0] if_id_pc4,
    output logic [5:0]      op,
    output logic [5:0]      func
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);
    if_state_t       state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_addr;
    logic            fresh;
    logic            accept;
    logic            capture;
    logic            park;
    logic            unload;
    logic            skid_vld;
    logic [PC_W-1:0] skid_dat;
    logic [PC_W-1:0] skid_pc4;

    assign pc_plus4 = pc + PC_W'(4);
    assign br_addr  = branch_target & ~PC_W'(3);

    // A ready in the first cycle out of reset may answer a request the reset abandoned.
    assign accept  = imem.imem_ready && !fresh && (state != HOLD);
    assign capture = (state == FETCH) && accept && !stall && !branch_taken;
    assign park    = (state == FETCH) && accept && stall && !branch_taken;
    assign unload  = (state == HOLD) && skid_vld && !stall && !branch_taken;

    assign imem.imem_req  = !rst && (state != HOLD);
    assign imem.imem_addr = pc;

    assign op   = if_id_instr[OP_MSB:OP_LSB];
    assign func = if_id_instr[FUNC_MSB:FUNC_LSB];

    if_skid_buf #(.PC_W(PC_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (park),
        .unload   (unload),
        .clear    (branch_taken),
        .load_dat (imem.imem_rdata),
        .load_pc4 (pc_plus4),
        .valid    (skid_vld),
        .data     (skid_dat),
        .pc4      (skid_pc4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC & ~PC_W'(3);
            redirect_pc <= '0;
            fresh       <= 1'b1;
            if_id_valid <= 1'b0;
            if_id_instr <= PC_W'(NOP_INSTR);
            if_id_pc4   <= '0;
        end else begin
            fresh <= 1'b0;
            if (branch_taken) begin
                if_id_valid <= 1'b0;
                if_id_instr <= PC_W'(NOP_INSTR);
                // With the request still in flight its response must be swallowed first.
                if ((state == HOLD) || accept) begin
                    pc    <= br_addr;
                    state <= FETCH;
                end else begin
                    redirect_pc <= br_addr;
                    state       <= DROP;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (capture) begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem.imem_rdata;
                            if_id_pc4   <= pc_plus4;
                        end else if (!accept && !stall) begin
                            if_id_valid <= 1'b0;
                            if_id_instr <= PC_W'(NOP_INSTR);
                        end
                        if (accept) pc <= pc_plus4;
                        if (park) state <= HOLD;
                    end
                    HOLD: begin
                        if (unload) begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= skid_dat;
                            if_id_pc4   <= skid_pc4;
                            state       <= FETCH;
                        end
                    end
                    DROP: begin
                        if (accept) begin
                            pc    <= redirect_pc;
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (capture || unload) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, RESET_PC wrap instance, random run against a queue model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc4;
    logic [5:0]  op, func;

    logic        rst2, stall2, br2;
    logic [31:0] tgt2;
    logic        valid2;
    logic [31:0] instr2, pc4_2;
    logic [5:0]  op2, func2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_stage_if #(.PC_W(32)) imem_bus ();
    if_id_stage_if #(.PC_W(32)) bus2 ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, pf2, ps2;
`endif

    if_id_stage #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(imem_bus), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .op(op), .func(func)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    if_id_stage #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .imem(bus2), .stall(stall2), .branch_taken(br2),
        .branch_target(tgt2), .if_id_valid(valid2), .if_id_instr(instr2),
        .if_id_pc4(pc4_2), .op(op2), .func(func2)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Directed vectors: inputs for a cycle and the outputs expected in that same cycle.
    typedef struct {
        logic        rst, rdy, stall, br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr, e_pc4;
    } vec_t;
    vec_t tv[$];

    task automatic addv(input logic r, input logic y, input logic s, input logic b, input logic [31:0] t,
                        input logic q, input logic [31:0] a, input logic v, input logic [31:0] i,
                        input logic [31:0] p);
        vec_t e;
        e.rst = r; e.rdy = y; e.stall = s; e.br = b; e.tgt = t;
        e.e_req = q; e.e_addr = a; e.e_vld = v; e.e_instr = i; e.e_pc4 = p;
        tv.push_back(e);
    endtask

    // Reference model: fetch pointer, pending redirect, parked words as a queue, IF/ID contents.
    typedef struct { logic [31:0] instr, pc4; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_addr, m_tgt, m_instr, m_pc4;
    bit          m_drop, m_fresh, m_vld;
    int unsigned m_fetch, m_stall;

    task automatic model_step(input bit r, input bit rdy, input bit s, input bit b,
                              input logic [31:0] t, input logic [31:0] rdata);
        bit got;
        if (r) begin
            m_addr = 32'h0; m_drop = 0; m_q.delete(); m_fresh = 1;
            m_vld = 0; m_instr = 32'h0; m_pc4 = 32'h0; m_fetch = 0; m_stall = 0;
        end else begin
            got = rdy && !m_fresh && (m_q.size() == 0);
            m_fresh = 0;
            if (s) m_stall++;
            if (b) begin
                m_vld = 0; m_instr = 32'h0;
                if (m_q.size() > 0 || got) begin
                    m_q.delete(); m_drop = 0; m_addr = t & 32'hFFFF_FFFC;
                end else begin
                    m_drop = 1; m_tgt = t & 32'hFFFF_FFFC;
                end
            end else if (m_q.size() > 0) begin
                if (!s) begin
                    m_vld = 1; m_instr = m_q[0].instr; m_pc4 = m_q[0].pc4;
                    void'(m_q.pop_front()); m_fetch++;
                end
            end else if (m_drop) begin
                if (got) begin m_drop = 0; m_addr = m_tgt; end
            end else if (got) begin
                if (s) m_q.push_back('{rdata, m_addr + 32'd4});
                else begin
                    m_vld = 1; m_instr = rdata; m_pc4 = m_addr + 32'd4; m_fetch++;
                end
                m_addr = m_addr + 32'd4;
            end else if (!s) begin
                m_vld = 0; m_instr = 32'h0;
            end
        end
    endtask

    initial begin
        bit r_rst, r_stall, r_br, r_rdy;
        logic [31:0] r_tgt, r_rdata;

        rst = 1; stall = 0; br = 0; tgt = 0;
        imem_bus.imem_ready = 0; imem_bus.imem_rdata = 0;
        rst2 = 1; stall2 = 0; br2 = 0; tgt2 = 0;
        bus2.imem_ready = 1; bus2.imem_rdata = 0;

        //   rst rdy stl br  tgt           req addr          vld instr         pc4
        addv(1, 1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h4);
        addv(0, 1, 1, 0, 32'h0,         1, 32'h8,        1, 32'h4,        32'h8);
        addv(0, 1, 1, 0, 32'h0,         0, 32'hC,        1, 32'h4,        32'h8);
        addv(0, 1, 1, 0, 32'h0,         0, 32'hC,        1, 32'h4,        32'h8);
        addv(0, 1, 0, 0, 32'h0,         0, 32'hC,        1, 32'h4,        32'h8);
        addv(0, 1, 0, 0, 32'h0,         1, 32'hC,        1, 32'h8,        32'hC);
        addv(0, 1, 0, 1, 32'h103,       1, 32'h10,       1, 32'hC,        32'h10);
        addv(0, 0, 0, 0, 32'h0,         1, 32'h100,      0, 32'h0,        32'h10);
        addv(0, 0, 0, 1, 32'h200,       1, 32'h100,      0, 32'h0,        32'h10);
        addv(0, 0, 0, 0, 32'h0,         1, 32'h100,      0, 32'h0,        32'h10);
        addv(0, 0, 0, 0, 32'h0,         1, 32'h100,      0, 32'h0,        32'h10);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h100,      0, 32'h0,        32'h10);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h200,      0, 32'h0,        32'h10);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h204,      1, 32'h200,      32'h204);
        addv(1, 1, 0, 0, 32'h0,         0, 32'h208,      1, 32'h204,      32'h208);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0);
        addv(0, 1, 0, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h4);

        repeat (2) @(negedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; stall = tv[i].stall; br = tv[i].br; tgt = tv[i].tgt;
            imem_bus.imem_ready = tv[i].rdy;
            imem_bus.imem_rdata = imem_bus.imem_addr;
            #1;
            chk($sformatf("vec%0d.req", i),   32'(imem_bus.imem_req), 32'(tv[i].e_req));
            chk($sformatf("vec%0d.addr", i),  imem_bus.imem_addr,     tv[i].e_addr);
            chk($sformatf("vec%0d.valid", i), 32'(if_id_valid),       32'(tv[i].e_vld));
            chk($sformatf("vec%0d.instr", i), if_id_instr,            tv[i].e_instr);
            chk($sformatf("vec%0d.pc4", i),   if_id_pc4,              tv[i].e_pc4);
        end

        // RESET_PC at the top of the address space: the second fetch wraps to zero.
        @(negedge clk);
        rst2 = 0; bus2.imem_rdata = bus2.imem_addr; #1;
        chk("wrap.req1", 32'(bus2.imem_req), 32'h1);
        chk("wrap.addr1", bus2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        bus2.imem_rdata = bus2.imem_addr; #1;
        chk("wrap.addr2", bus2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        bus2.imem_rdata = bus2.imem_addr; #1;
        chk("wrap.addr3", bus2.imem_addr, 32'h0);
        chk("wrap.valid", 32'(valid2), 32'h1);
        chk("wrap.instr", instr2, 32'hFFFF_FFFC);
        chk("wrap.pc4", pc4_2, 32'h0);
        chk("wrap.op", 32'(op2), 32'h3F);
        chk("wrap.func", 32'(func2), 32'h3C);

        // Random run against the model, starting from a reset cycle.
        @(negedge clk);
        rst = 1; stall = 0; br = 0; imem_bus.imem_ready = 0;
        model_step(1, 0, 0, 0, 32'h0, 32'h0);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            r_rst   = ($urandom_range(0, 99) == 0);
            r_stall = ($urandom_range(0, 99) < 30);
            r_br    = ($urandom_range(0, 99) < 8);
            r_tgt   = $urandom;
            r_rdy   = (m_q.size() == 0) && ($urandom_range(0, 1) == 1);
            r_rdata = $urandom;
            rst = r_rst; stall = r_stall; br = r_br; tgt = r_tgt;
            imem_bus.imem_ready = r_rdy; imem_bus.imem_rdata = r_rdata;
            #1;
            chk("rnd.req",   32'(imem_bus.imem_req), 32'(!r_rst && (m_q.size() == 0)));
            chk("rnd.addr",  imem_bus.imem_addr,     m_addr);
            chk("rnd.valid", 32'(if_id_valid),       32'(m_vld));
            chk("rnd.instr", if_id_instr,            m_instr);
            chk("rnd.pc4",   if_id_pc4,              m_pc4);
            chk("rnd.op",    32'(op),                32'(m_instr[31:26]));
            chk("rnd.func",  32'(func),              32'(m_instr[5:0]));
            model_step(r_rst, r_rdy, r_stall, r_br, r_tgt, r_rdata);
        end

`ifdef IF_PERF_CNT_EN
        @(negedge clk);
        stall = 0; br = 0; imem_bus.imem_ready = 0; #1;
        chk("rnd.perf_fetch", perf_fetch_cnt, 32'(m_fetch));
        chk("rnd.perf_stall", perf_stall_cnt, 32'(m_stall));
        rst = 1;
        @(negedge clk);
        rst = 0; imem_bus.imem_ready = 1;
        repeat (11) @(negedge clk);
        imem_bus.imem_ready = 0; stall = 1;
        repeat (4) @(negedge clk);
        stall = 0; #1;
        chk("perf.fetch10", perf_fetch_cnt, 32'd10);
        chk("perf.stall4", perf_stall_cnt, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
